// File: rtl/request_unit_ctrl.sv
// Request unit between control and the I/D caches: turns one-cycle control intents
// into held memory request levels, with atomic tagging, flush cancel, watchdog and counter.
module request_unit_ctrl #(
    parameter bit          ATOMIC_EN = 1'b1,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iread,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             datomic_in,
    input  logic             halt,
    input  logic             flush,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             datomic,
    output logic             dpending,
    output logic             timeout,
    output logic [CNT_W-1:0] dacc_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              atom_q, atom_d;
    logic              tmo_q, tmo_d;
    logic              halted_q, halted_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and request registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            atom_q   <= 1'b0;
            tmo_q    <= 1'b0;
            halted_q <= 1'b0;
            wait_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            atom_q   <= atom_d;
            tmo_q    <= tmo_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: request capture, completion, cancel and watchdog
    always_comb begin
        state_d  = state_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        atom_d   = atom_q;
        tmo_d    = tmo_q;
        halted_d = halted_q | halt;
        wait_d   = wait_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (ihit && (dread || dwrite) && !flush) begin
                    state_d = DREQ;
                    wen_d   = dwrite;
                    ren_d   = dread & ~dwrite;
                    atom_d  = datomic_in & ATOMIC_EN;
                    wait_d  = '0;
                end
            end
            DREQ: begin
                // dhit takes priority over flush so a completing access is counted
                if (dhit) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    atom_d  = 1'b0;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (flush) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    atom_d  = 1'b0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    atom_d  = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERR: begin
                ren_d  = 1'b0;
                wen_d  = 1'b0;
                atom_d = 1'b0;
                tmo_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
                atom_d  = 1'b0;
            end
        endcase
    end

    assign imemREN    = iread & ~halted_q & ~tmo_q;
    assign dmemREN    = ren_q;
    assign dmemWEN    = wen_q;
    assign datomic    = atom_q;
    assign dpending   = (state_q == DREQ);
    assign timeout    = tmo_q;
    assign dacc_count = cnt_q;

endmodule
